mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single 32-bit Avalon-MM master between instruction fetch and the memory stage.
- Memory-stage accesses are scalar (1 word) or vector (VEC_LANES words). Vector accesses are sequenced into consecutive word beats, and the 128-bit read result is reassembled.
- Drives stall_all to freeze the whole pipeline while any accepted requester is still waiting.

Parameters:
- WORD_W, 32, Avalon data width and scalar width.
- VEC_LANES, 4, words per vector access (vector width = WORD_W*VEC_LANES = 128).

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held high until if_ready.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched instruction; valid when if_ready.
- if_ready  out  1  one-cycle completion pulse for fetch.
- mem_read  in  1  memory-stage read request; held until mem_ready.
- mem_write  in  1  memory-stage write request; held until mem_ready.
- mem_vector  in  1  1 = VEC_LANES-beat access, 0 = single word.
- mem_addr  in  32  memory-stage byte address.
- mem_wdata  in  128  write data; lane i = bits [32i+31:32i].
- mem_rdata  out  128  read data; valid when mem_ready.
- mem_ready  out  1  one-cycle completion pulse for memory stage.
- avm_address  out  32  Avalon byte address.
- avm_read  out  1  Avalon read.
- avm_write  out  1  Avalon write.
- avm_writedata  out  32  Avalon write data.
- avm_readdata  in  32  Avalon read data; valid when avm_read=1 and avm_waitrequest=0.
- avm_waitrequest  in  1  Avalon stall.
- stall_all  out  1  pipeline freeze.

Behaviour:
- Reset:
  - State IDLE, beat=0.
  - avm_read, avm_write, if_ready and mem_ready are 0.
  - avm_address, avm_writedata, if_rdata and mem_rdata are 0.
- States: IDLE, DATA, FETCH, DONE.
- IDLE arbitration:
  - Memory stage has fixed priority over fetch, because it holds the older instruction.
  - mem_read or mem_write asserted: latch address/op/vector/wdata, set beat=0, go to DATA.
  - Otherwise, if_req asserted: latch if_addr, go to FETCH.
- mem_read and mem_write both high: treated as a write.
- Beat address: {addr[31:2],2'b00} + 4*beat. Low two address bits are ignored.
- DATA state:
  - Drives avm_read or avm_write with the beat address.
  - avm_writedata = lane[beat].
  - Command held stable while avm_waitrequest=1.
  - Beat completes on a cycle with avm_waitrequest=0. On a read, avm_readdata is captured into lane[beat] of mem_rdata.
  - Last beat (beat = VEC_LANES-1 for a vector access, beat 0 for scalar): deassert the command on the next edge and go to DONE with mem_ready=1.
  - Otherwise: beat+1 and stay in DATA. There are no idle cycles between beats.
- Scalar reads: lanes 1..3 of mem_rdata are zero.
- FETCH state: single read beat. On completion, capture if_rdata and go to DONE with if_ready=1.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - No arbitration happens in DONE. This stops a requester that is still high from being served twice.
- stall_all (combinational) = ((mem_read|mem_write) & ~mem_ready) | (if_req & ~if_ready).
- A request that arrives while the other requester is being served waits, and stall_all stays high.
- Minimum latency with waitrequest=0:
  - scalar or fetch: ready 2 cycles after the request edge;
  - vector: 5 cycles.
- rst during DATA/FETCH: the transfer is aborted, the command drops at the same edge, and neither ready pulses.
- Changes to request inputs after the latch edge are ignored until DONE.

Test Plan:
- Scalar read at mem_addr=0x100, avm_readdata=0xDEADBEEF, waitrequest=0 → avm_address=0x100 for 1 cycle. 2 cycles after the request edge: mem_ready=1 and mem_rdata=0x...0000_DEADBEEF. stall_all drops in the same cycle.
- Vector write at addr 0x200 with wdata lanes A,B,C,D, and waitrequest=1 for 2 cycles on beat 1 → writes A@0x200, B@0x204 (held 3 cycles), C@0x208, D@0x20C. mem_ready pulses once, after D.
- Simultaneous if_req (0x40) and mem_read (0x300) → data read served first. A fetch of 0x40 follows, starting after DONE, with one idle cycle. if_ready pulses once, and stall_all stays high throughout.
- Vector read of 0x10,0x20,0x30,0x40 at addr 0x403 → beat addresses 0x400..0x40C. mem_rdata=0x00000040_00000030_00000020_00000010.
- rst asserted during beat 2 of a vector read → avm_read=0 and state IDLE at the next edge, no mem_ready. A new request after reset completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit Avalon-MM master between instruction fetch and the memory stage.
// Vector accesses are split into back-to-back word beats and reassembled on reads.
module mem_port_arbiter #(
  parameter int WORD_W    = 32,
  parameter int VEC_LANES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          if_req,
  input  logic [31:0]                   if_addr,
  output logic [WORD_W-1:0]             if_rdata,
  output logic                          if_ready,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic                          mem_vector,
  input  logic [31:0]                   mem_addr,
  input  logic [WORD_W*VEC_LANES-1:0]   mem_wdata,
  output logic [WORD_W*VEC_LANES-1:0]   mem_rdata,
  output logic                          mem_ready,
  output logic [31:0]                   avm_address,
  output logic                          avm_read,
  output logic                          avm_write,
  output logic [WORD_W-1:0]             avm_writedata,
  input  logic [WORD_W-1:0]             avm_readdata,
  input  logic                          avm_waitrequest,
  output logic                          stall_all,
  output logic [1:0]                    state_dbg
);

  localparam int BEAT_W = (VEC_LANES > 1) ? $clog2(VEC_LANES) : 1;
  localparam int VEC_W  = WORD_W * VEC_LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [BEAT_W-1:0]   beat;
  logic [BEAT_W-1:0]   beat_inc;
  logic                op_write;
  logic                op_vector;
  logic [VEC_W-1:0]    wdata_q;
  logic                last_beat;
  logic                unused_addr_bits;

  assign beat_inc  = beat + 1'b1;
  assign last_beat = op_vector ? (beat == BEAT_W'(VEC_LANES - 1)) : 1'b1;
  assign state_dbg = state;
  // Byte-lane bits never reach the bus: every beat is word aligned.
  assign unused_addr_bits = ^{mem_addr[1:0], if_addr[1:0]};

  assign stall_all = ((mem_read | mem_write) & ~mem_ready) | (if_req & ~if_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat          <= '0;
      op_write      <= 1'b0;
      op_vector     <= 1'b0;
      wdata_q       <= '0;
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      if_rdata      <= '0;
      if_ready      <= 1'b0;
      mem_rdata     <= '0;
      mem_ready     <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          // Memory stage wins: it carries the older instruction.
          if (mem_read | mem_write) begin
            op_write      <= mem_write;
            op_vector     <= mem_vector;
            wdata_q       <= mem_wdata;
            beat          <= '0;
            avm_address   <= {mem_addr[31:2], 2'b00};
            avm_read      <= ~mem_write;
            avm_write     <= mem_write;
            avm_writedata <= mem_wdata[WORD_W-1:0];
            mem_rdata     <= '0;
            state         <= DATA;
          end else if (if_req) begin
            avm_address <= {if_addr[31:2], 2'b00};
            avm_read    <= 1'b1;
            state       <= FETCH;
          end
        end
        DATA: begin
          if (!avm_waitrequest) begin
            if (!op_write) begin
              mem_rdata[int'(beat)*WORD_W +: WORD_W] <= avm_readdata;
            end
            if (last_beat) begin
              avm_read  <= 1'b0;
              avm_write <= 1'b0;
              mem_ready <= 1'b1;
              state     <= DONE;
            end else begin
              beat          <= beat_inc;
              avm_address   <= avm_address + 32'd4;
              avm_writedata <= wdata_q[int'(beat_inc)*WORD_W +: WORD_W];
            end
          end
        end
        FETCH: begin
          if (!avm_waitrequest) begin
            if_rdata <= avm_readdata;
            avm_read <= 1'b0;
            if_ready <= 1'b1;
            state    <= DONE;
          end
        end
        // One dead cycle so a requester still holding its line is not served twice.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences and random
// traffic against a word-array memory model with an expected-beat scoreboard.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         if_req = 1'b0;
  logic [31:0]  if_addr = '0;
  logic [31:0]  if_rdata;
  logic         if_ready;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic         mem_vector = 1'b0;
  logic [31:0]  mem_addr = '0;
  logic [127:0] mem_wdata = '0;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [31:0]  avm_address;
  logic         avm_read;
  logic         avm_write;
  logic [31:0]  avm_writedata;
  logic [31:0]  avm_readdata;
  logic         avm_waitrequest = 1'b0;
  logic         stall_all;
  logic [1:0]   state_dbg;

  mem_port_arbiter #(.WORD_W(32), .VEC_LANES(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_vector(mem_vector),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .stall_all(stall_all), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model and Avalon slave ----------------
  logic [31:0] slave_mem [512];
  logic [31:0] ref_mem   [512];
  int          plan_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_d_q[$];
  bit          exp_w_q[$];

  assign avm_readdata = slave_mem[avm_address[10:2]];

  function automatic int pick();
    if (plan_q.size() > 0) return plan_q.pop_front();
    return 0;
  endfunction

  bit          in_beat = 0;
  int          stall_left = 0;
  logic [31:0] hold_addr, hold_data;
  int          mem_ready_cnt = 0;
  int          if_ready_cnt = 0;

  // Slave + monitor: runs mid-cycle, decides waitrequest for the coming edge.
  always @(negedge clk) begin
    if (mem_ready) mem_ready_cnt++;
    if (if_ready) if_ready_cnt++;
    if (rst || !(avm_read || avm_write)) begin
      in_beat = 0;
      avm_waitrequest = 1'b0;
    end else begin
      if (!in_beat) begin
        in_beat    = 1;
        stall_left = pick();
        hold_addr  = avm_address;
        hold_data  = avm_writedata;
      end else begin
        chk("hold_addr", avm_address, hold_addr);
        if (avm_write) chk("hold_wdata", avm_writedata, hold_data);
      end
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
        in_beat = 0;
        chk("rd_wr_exclusive", avm_read & avm_write, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", avm_address, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] ea, ed;
          bit ew;
          ea = exp_q.pop_front();
          ew = exp_w_q.pop_front();
          ed = exp_d_q.pop_front();
          chk("beat_addr", avm_address, ea);
          chk("beat_is_write", avm_write, ew);
          if (ew) chk("beat_wdata", avm_writedata, ed);
        end
        if (avm_write) slave_mem[avm_address[10:2]] = avm_writedata;
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_mem(input bit wr, input bit vec, input logic [31:0] addr,
                           input logic [127:0] wd, output logic [127:0] rd);
    int base;
    int n;
    base = int'(addr / 4);
    n    = vec ? 4 : 1;
    rd   = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(32'((base + i) * 4));
      exp_w_q.push_back(wr);
      exp_d_q.push_back(wd[i*32 +: 32]);
      if (wr) ref_mem[base + i] = wd[i*32 +: 32];
      else    rd[i*32 +: 32] = ref_mem[base + i];
    end
  endtask

  task automatic model_fetch(input logic [31:0] addr, output logic [31:0] rd);
    exp_q.push_back(32'((addr / 4) * 4));
    exp_w_q.push_back(1'b0);
    exp_d_q.push_back('0);
    rd = ref_mem[addr / 4];
  endtask

  // ---------------- drivers ----------------
  task automatic do_mem(input bit wr, input bit both, input bit vec, input logic [31:0] addr,
                        input logic [127:0] wd, output logic [127:0] rd, output int lat);
    bit done;
    @(posedge clk); #1;
    mem_read   = !wr || both;
    mem_write  = wr;
    mem_vector = vec;
    mem_addr   = addr;
    mem_wdata  = wd;
    lat  = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (mem_ready) begin
        done = 1;
        chk("stall_all_at_ready", stall_all, 0);
      end else begin
        lat++;
        chk("stall_all_busy", stall_all, 1);
        if (lat > 200) begin
          chk("mem_ready_timeout", 0, 1);
          done = 1;
        end
      end
    end
    rd = mem_rdata;
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    chk("mem_ready_one_cycle", mem_ready, 0);
  endtask

  task automatic do_fetch(input logic [31:0] addr, output logic [31:0] rd, output int lat);
    bit done;
    @(posedge clk); #1;
    if_req  = 1'b1;
    if_addr = addr;
    lat  = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (if_ready) begin
        done = 1;
      end else begin
        lat++;
        if (lat > 200) begin
          chk("if_ready_timeout", 0, 1);
          done = 1;
        end
      end
    end
    rd = if_rdata;
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("if_ready_one_cycle", if_ready, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit           wr;
    bit           both;
    bit           vec;
    logic [31:0]  addr;
    logic [127:0] wdata;
    int           stall_beat;
    int           stall_cyc;
    logic [127:0] exp_rd;
    int           exp_lat;
  } vec_t;

  localparam logic [127:0] ABCD = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};

  vec_t tbl [9];

  initial begin
    logic [127:0] rd, mrd, exp_rd;
    logic [31:0]  ird, exp_ird;
    int lat, cyc, m_at, i_at, m_cnt0, i_cnt0;

    for (int i = 0; i < 512; i++) begin
      ref_mem[i]   = $urandom();
      slave_mem[i] = ref_mem[i];
    end
    ref_mem[32'h100 / 4] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) ref_mem[32'h400 / 4 + i] = 32'((i + 1) * 16);
    for (int i = 0; i < 512; i++) slave_mem[i] = ref_mem[i];

    tbl[0] = '{0, 0, 0, 32'h100, '0, -1, 0, {96'h0, 32'hDEADBEEF}, 2};
    tbl[1] = '{1, 0, 1, 32'h200, ABCD, 1, 2, '0, 7};
    tbl[2] = '{0, 0, 1, 32'h403, '0, -1, 0, 128'h00000040_00000030_00000020_00000010, 5};
    tbl[3] = '{0, 0, 0, 32'h204, '0, 0, 1, {96'h0, 32'hBBBB0002}, 3};
    tbl[4] = '{1, 0, 0, 32'h13, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h12345678}, -1, 0, '0, 2};
    tbl[5] = '{0, 0, 1, 32'h200, '0, 3, 1, ABCD, 6};
    tbl[6] = '{0, 0, 0, 32'h10, '0, -1, 0, {96'h0, 32'h12345678}, 2};
    tbl[7] = '{1, 1, 0, 32'h20, {96'h0, 32'hCAFEF00D}, -1, 0, '0, 2};
    tbl[8] = '{0, 0, 0, 32'h22, '0, -1, 0, {96'h0, 32'hCAFEF00D}, 2};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state_idle", state_dbg, 2'd0);
    chk("rst_avm_read", avm_read, 0);
    chk("rst_avm_write", avm_write, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_avm_address", avm_address, 0);
    chk("rst_avm_writedata", avm_writedata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven memory-stage transactions
    for (int t = 0; t < 9; t++) begin
      int nb;
      nb = tbl[t].vec ? 4 : 1;
      for (int b = 0; b < nb; b++) plan_q.push_back(b == tbl[t].stall_beat ? tbl[t].stall_cyc : 0);
      model_mem(tbl[t].wr, tbl[t].vec, tbl[t].addr, tbl[t].wdata, exp_rd);
      m_cnt0 = mem_ready_cnt;
      do_mem(tbl[t].wr, tbl[t].both, tbl[t].vec, tbl[t].addr, tbl[t].wdata, rd, lat);
      chk($sformatf("tbl%0d_latency", t), lat, tbl[t].exp_lat);
      chk($sformatf("tbl%0d_ready_pulses", t), mem_ready_cnt - m_cnt0, 1);
      if (!tbl[t].wr) chk($sformatf("tbl%0d_rdata", t), rd, tbl[t].exp_rd);
    end
    chk("tbl_beats_drained", exp_q.size(), 0);

    // Simultaneous fetch and data read: data first, fetch after the dead cycle
    model_mem(0, 0, 32'h300, '0, exp_rd);
    model_fetch(32'h40, exp_ird);
    m_cnt0 = mem_ready_cnt;
    i_cnt0 = if_ready_cnt;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40;
    mem_read = 1'b1; mem_vector = 1'b0; mem_addr = 32'h300;
    cyc = 0; m_at = -1; i_at = -1;
    mrd = '0; ird = '0;
    while (i_at < 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mem_ready) begin m_at = cyc; mrd = mem_rdata; end
      if (if_ready) begin
        i_at = cyc;
        ird = if_rdata;
      end else begin
        chk("arb_stall_all_high", stall_all, 1);
      end
      @(posedge clk); #1;
      if (m_at == cyc) mem_read = 1'b0;
      if (i_at == cyc) if_req = 1'b0;
    end
    @(negedge clk);
    chk("arb_if_completed", i_at > 0, 1);
    chk("arb_mem_first", m_at, 3);
    chk("arb_fetch_gap", i_at - m_at, 3);
    chk("arb_mem_rdata", mrd, exp_rd);
    chk("arb_if_rdata", ird, exp_ird);
    chk("arb_mem_pulses", mem_ready_cnt - m_cnt0, 1);
    chk("arb_if_pulses", if_ready_cnt - i_cnt0, 1);
    chk("arb_beats_drained", exp_q.size(), 0);

    // Reset during beat 2 of a vector read
    plan_q = {0, 0, 5};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'h300 + 32'(4 * i));
      exp_w_q.push_back(1'b0);
      exp_d_q.push_back('0);
    end
    m_cnt0 = mem_ready_cnt;
    @(posedge clk); #1;
    mem_read = 1'b1; mem_vector = 1'b1; mem_addr = 32'h300;
    repeat (4) @(negedge clk);
    chk("abort_beat2_addr", avm_address, 32'h308);
    chk("abort_beat2_read", avm_read, 1);
    rst = 1'b1;
    mem_read = 1'b0;
    mem_vector = 1'b0;
    @(negedge clk);
    chk("abort_avm_read", avm_read, 0);
    chk("abort_state_idle", state_dbg, 2'd0);
    chk("abort_no_ready", mem_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    plan_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_ready_count", mem_ready_cnt - m_cnt0, 0);
    chk("abort_beats_drained", exp_q.size(), 0);
    model_mem(0, 0, 32'h100, '0, exp_rd);
    do_mem(0, 0, 0, 32'h100, '0, rd, lat);
    chk("after_abort_rdata", rd, exp_rd);
    chk("after_abort_latency", lat, 2);

    // Random traffic against the model
    for (int t = 0; t < 40; t++) begin
      int kind, idx, stalls, nb;
      bit wr, both, vec;
      logic [31:0] addr;
      logic [127:0] wd;
      kind = $urandom_range(0, 3);
      idx  = $urandom_range(0, 508);
      addr = 32'(idx * 4) + 32'($urandom_range(0, 3));
      if (kind == 0) begin
        stalls = $urandom_range(0, 2);
        plan_q.push_back(stalls);
        model_fetch(addr, exp_ird);
        do_fetch(addr, ird, lat);
        chk("rnd_fetch_data", ird, exp_ird);
        chk("rnd_fetch_latency", lat, 2 + stalls);
      end else begin
        wr   = 1'($urandom_range(0, 1));
        both = wr && ($urandom_range(0, 3) == 0);
        vec  = 1'($urandom_range(0, 1));
        wd   = {$urandom(), $urandom(), $urandom(), $urandom()};
        nb   = vec ? 4 : 1;
        stalls = 0;
        for (int b = 0; b < nb; b++) begin
          int s;
          s = $urandom_range(0, 2);
          stalls += s;
          plan_q.push_back(s);
        end
        model_mem(wr, vec, addr, wd, exp_rd);
        do_mem(wr, both, vec, addr, wd, rd, lat);
        chk("rnd_mem_latency", lat, (vec ? 5 : 2) + stalls);
        if (!wr) chk("rnd_mem_rdata", rd, exp_rd);
      end
    end
    chk("final_beats_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
